// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code encoding and FSM states.
// Also imported by the control unit so both sides agree on alu_ctr values.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MULT = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // SLT is evaluated through the same a + ~b + 1 adder as SUB.
  function automatic logic op_uses_sub(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_mult_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
// Compiled only when ALU_MULT_EN is defined.
`ifdef ALU_MULT_EN
module alu_mult_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod_next
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mpl_q, mpl_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] src_acc, src_mpl, src_mcand;
  logic [WIDTH:0]   sum;

  // The load edge already performs iteration 0 on the fresh operands, so the
  // remaining WIDTH-1 iterations fit in the WIDTH-1 busy cycles.
  always_comb begin
    src_acc   = load ? '0 : acc_q;
    src_mpl   = load ? b  : mpl_q;
    src_mcand = load ? a  : mcand_q;
    sum       = {1'b0, src_acc} + (src_mpl[0] ? {1'b0, src_mcand} : '0);
    prod_next = {sum, src_mpl[WIDTH-1:1]};

    acc_d   = acc_q;
    mpl_d   = mpl_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    if (load || step) begin
      acc_d   = sum[WIDTH:1];
      mpl_d   = {sum[0], src_mpl[WIDTH-1:1]};
      mcand_d = src_mcand;
      cnt_d   = load ? '0 : cnt_q + CW'(1);
    end
  end

  assign last = (cnt_q == CW'(WIDTH-2));

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // NOTE: datapath registers carry no reset; load always initialises them
  // before any value is consumed, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    mpl_q   <= mpl_d;
    mcand_q <= mcand_d;
  end

endmodule
`endif

// File: rtl/alu_nbit_seq.sv
// WIDTH-bit registered ALU with start/busy/done handshake for the execute stage.
// Define ALU_MULT_EN to build the iterative multiplier; otherwise MULT returns 0.
module alu_nbit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  import alu_pkg::*;

  alu_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic             add_ovf;
  logic             slt_bit;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;
  logic             take_mult;

  always_comb begin
    sub_op  = op_uses_sub(alu_ctr);
    b_eff   = sub_op ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
    // Sign of the exact difference: flipping on overflow keeps SLT correct.
    slt_bit = sum_ext[WIDTH-1] ^ add_ovf;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (alu_ctr)
      ALU_AND: op_res = a & b;
      ALU_OR:  op_res = a | b;
      ALU_NOR: op_res = ~(a | b);
      ALU_XOR: op_res = a ^ b;
      ALU_ADD, ALU_SUB: begin
        op_res = sum_ext[WIDTH-1:0];
        op_c   = sum_ext[WIDTH];
        op_v   = add_ovf;
      end
      ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: ;
    endcase
  end

`ifdef ALU_MULT_EN
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  assign take_mult = (alu_ctr == ALU_MULT);
  assign mul_load  = start && take_mult && (state_q != MUL);
  assign mul_step  = (state_q == MUL);

  alu_mult_iter #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mul_load),
    .step      (mul_step),
    .a         (a),
    .b         (b),
    .last      (mul_last),
    .prod_next (mul_prod)
  );
`else
  assign take_mult = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    c_out_d     = c_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    case (state_q)
      MUL: begin
`ifdef ALU_MULT_EN
        if (mul_last) begin
          state_d     = DONE;
          result_d    = mul_prod[WIDTH-1:0];
          result_hi_d = mul_prod[2*WIDTH-1:WIDTH];
          c_out_d     = 1'b0;
          overflow_d  = 1'b0;
          zero_d      = ~|mul_prod[WIDTH-1:0];
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        if (!start) begin
          state_d = IDLE;
        end else if (take_mult) begin
          state_d = MUL;
        end else begin
          state_d     = DONE;
          result_d    = op_res;
          result_hi_d = '0;
          c_out_d     = op_c;
          overflow_d  = op_v;
          zero_d      = ~|op_res;
        end
      end
    endcase
    busy_d = (state_d == MUL);
    done_d = (state_d == DONE);
  end

  // NOTE: state and outputs use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      c_out_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      c_out_q     <= c_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq at WIDTH=8: driver pushes model results,
// a negedge monitor pops them when done is due and checks held outputs otherwise.
module tb_alu_nbit_seq;
  import alu_pkg::*;

  localparam int W = 8;
`ifdef ALU_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         v;
    logic         z;
  } rsp_t;

  typedef struct {
    int   due;
    rsp_t r;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   alu_ctr;
  logic [W-1:0] a, b;
  logic         busy, done, c_out, overflow, zero;
  logic [W-1:0] result, result_hi;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  rsp_t last;
  rsp_t rst_rsp;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu_ctr   (alu_ctr),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the operation rules, using integer arithmetic.
  function automatic rsp_t model(input logic [2:0] op, input logic [W-1:0] oa, input logic [W-1:0] ob);
    rsp_t r;
    int ua, ub, sa, sb, s, v;
    logic [31:0] val;
    ua = int'(oa);
    ub = int'(ob);
    sa = int'($signed(oa));
    sb = int'($signed(ob));
    r.hi = '0;
    r.c  = 1'b0;
    r.v  = 1'b0;
    val  = '0;
    case (op)
      ALU_AND: val = 32'(oa & ob);
      ALU_OR:  val = 32'(oa | ob);
      ALU_NOR: val = 32'(~(oa | ob));
      ALU_XOR: val = 32'(oa ^ ob);
      ALU_ADD: begin
        v = ua + ub;  val = v;
        r.c = (v > 255);
        s = sa + sb;  r.v = (s > 127) || (s < -128);
      end
      ALU_SUB: begin
        v = ua - ub;  val = v;
        r.c = (ua >= ub);
        s = sa - sb;  r.v = (s > 127) || (s < -128);
      end
      ALU_SLT: val = (sa < sb) ? 32'd1 : 32'd0;
      default: begin
        if (MULT_EN) begin
          v = ua * ub;  val = v;
          r.hi = val[15:8];
        end
      end
    endcase
    r.res = val[W-1:0];
    r.z   = (r.res == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] corners [5];
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  // Monitor: done must appear exactly when an expectation is due; outputs
  // must otherwise hold the last completed result.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_done;
      exp_done = (q.size() != 0) && (q[0].due == cyc);
      check("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      check("done", done, exp_done);
      if (exp_done) last = q.pop_front().r;
      check("result",    result,    last.res);
      check("result_hi", result_hi, last.hi);
      check("c_out",     c_out,     last.c);
      check("overflow",  overflow,  last.v);
      check("zero",      zero,      last.z);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] oa, input logic [W-1:0] ob);
    exp_t e;
    int   c;
    c = cyc;
    start = 1'b1;  alu_ctr = op;  a = oa;  b = ob;
    e.r = model(op, oa, ob);
    if (MULT_EN && op == ALU_MULT) begin
      e.due = c + W;
      busy_lo = c + 1;
      busy_hi = c + W - 1;
      q.push_back(e);
      // Random start pulses and operand churn while busy must be ignored.
      for (int j = 1; j < W; j++) begin
        step();
        start   = 1'($urandom_range(0, 1));
        alu_ctr = 3'($urandom);
        a       = W'($urandom);
        b       = W'($urandom);
      end
      step();
      start = 1'b0;
    end else begin
      e.due = c + 1;
      q.push_back(e);
      step();
      start = 1'b0;
    end
  endtask

  task automatic do_reset(input bit with_start);
    rst_n = 1'b0;
    if (with_start) begin
      start = 1'b1;  alu_ctr = ALU_ADD;  a = rand_operand();  b = rand_operand();
    end
    q.delete();
    busy_lo = 1;
    busy_hi = 0;
    last = rst_rsp;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_rsp = '{res: '0, hi: '0, c: 1'b0, v: 1'b0, z: 1'b1};
    rst_n = 1'b0;  start = 1'b0;  alu_ctr = ALU_AND;  a = '0;  b = '0;
    step();
    last = rst_rsp;
    mon_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    issue(ALU_ADD, 8'h7F, 8'h01);
    step();
    issue(ALU_SUB, 8'h05, 8'h05);
    issue(ALU_SLT, 8'h80, 8'h01);
    issue(ALU_MULT, 8'hFF, 8'hFF);
    issue(ALU_ADD, 8'hFF, 8'h01);
    step();

    // MULT aborted by reset four edges after start.
    c = cyc;
    start = 1'b1;  alu_ctr = ALU_MULT;  a = 8'h12;  b = 8'h34;
    if (MULT_EN) begin
      busy_lo = c + 1;
      busy_hi = c + W - 1;
    end else begin
      q.push_back('{due: c + 1, r: model(ALU_MULT, 8'h12, 8'h34)});
    end
    step();
    start = 1'b0;
    step();
    step();
    do_reset(1'b0);

    issue(ALU_AND, 8'hF0, 8'h3C);
    issue(ALU_MULT, 8'h03, 8'h04);
    step();
    do_reset(1'b1);
    step();

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom), rand_operand(), rand_operand());
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 2)); g++) step();
      end
    end

    repeat (3) step();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_nbit_seq.md
# alu_nbit_seq

Parametrised WIDTH-bit registered ALU: the multi-bit, sequential successor to the 1-bit ALU cell, keeping the same 3-bit `alu_ctr` operation encoding. Single-cycle ops complete in one clock. An optional iterative shift-add multiplier takes WIDTH clocks. It sits in the MIPS execute stage behind a start/busy/done handshake, with registered result and flags.

## Interface
- WIDTH, 32, operand/result width (≥ 4)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  request; sampled only when busy=0
- alu_ctr  in  3  operation code, sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- busy  out  1  multiplier iterating; start ignored
- done  out  1  one-cycle pulse: result/flags valid
- result  out  WIDTH  low result word
- result_hi  out  WIDTH  high product word (mult only, else 0)
- c_out  out  1  carry out (add), no-borrow (sub), else 0
- overflow  out  1  signed overflow (add/sub), else 0
- zero  out  1  result == 0

## Operation
- Codes: 000 AND, 001 OR, 010 ADD, 011 MULT (unsigned), 100 SLT (signed), 101 NOR, 110 SUB, 111 XOR.
- SUB = a + ~b + 1. c_out = carry out of bit WIDTH-1. overflow = operand signs equal (after inverting b for SUB) and result sign differs.
- SLT: result = {0…, signed(a) < signed(b)}. Uses the true sign of the subtraction, correct even on overflow. c_out=0, overflow=0.
- MULT: {result_hi, result} = a × b, 2·WIDTH bits, unsigned. zero reflects `result` only. c_out=0, overflow=0.
- FSM states: IDLE, MUL, DONE.
  - IDLE/DONE + start + non-MULT → DONE, outputs loaded.
  - IDLE/DONE + start + MULT → MUL, counter=0, operands latched.
  - DONE without start → IDLE.
  - MUL → MUL until counter = WIDTH-1, then → DONE.
- busy = (state==MUL). done = (state==DONE).
- result, result_hi and flags hold their value until the next done. They are not cleared on IDLE.
- start while busy: dropped, no queuing. a/b/alu_ctr changes during MUL have no effect.

## Timing
- Reset (rst_n low at a clock edge): state IDLE. busy, done, result, result_hi, c_out, overflow = 0. zero = 1. An in-flight MULT is aborted with no done.
- Single-cycle op: start at edge k → done=1 and outputs valid after edge k+1, for exactly one cycle.
- MULT: start at edge k → busy high after edges k+1..k+WIDTH-1 → done after edge k+WIDTH. One iteration per edge; latency = WIDTH.
- Back-to-back: start held high in the DONE cycle is accepted. This gives single-cycle ops a throughput of one per clock.
- rst_n low in the same cycle as start: reset wins.

## Configuration
- `ALU_MULT_EN` defined: multiplier and MUL state compiled in, behaviour as above.
- Not defined: no multiplier logic and busy tied 0. Code 011 completes as a single-cycle op with result=0, result_hi=0, zero=1, c_out=0, overflow=0.

## Structure
- Package `alu_pkg`: op-code localparams (ALU_AND … ALU_XOR) and FSM state encoding (IDLE, MUL, DONE). Shared with the control unit.
- Sub-module `alu_mult_iter`: shift-add datapath with accumulator, multiplier shift register and counter. Exposes load/step/last. Instantiated only under `ALU_MULT_EN`.
- Top holds the combinational single-cycle ops, flag logic, FSM and output registers.

## Test plan
- WIDTH=8, reset with rst_n=0 for 2 cycles → done=0, busy=0, result=0, zero=1.
- ADD a=0x7F b=0x01 start 1 cycle → next cycle done=1, result=0x80, overflow=1, c_out=0, zero=0.
- SUB a=0x05 b=0x05 → result=0x00, zero=1, c_out=1. Then SLT a=0x80 b=0x01 back-to-back → result=0x01, done held two cycles.
- MULT a=0xFF b=0xFF (`ALU_MULT_EN`) → busy for 7 cycles, done on cycle 8, result_hi=0xFE, result=0x01. A start pulsed mid-op is ignored.
- MULT a=0x12 b=0x34, rst_n low on cycle 4 → no done, all outputs reset. A following AND 0xF0&0x3C → 0x30.
- Build without `ALU_MULT_EN`: MULT a=0x03 b=0x04 → done after 1 cycle, result=0, result_hi=0, busy never high.
